// File: rtl/pl_ps_axi_regbank.sv
// pl_ps_axi_regbank: AXI4-Lite slave register bank.
//
// The write path holds the AW and W channels in two capture slots that fill
// independently. A write commits once both slots are full. The read path
// registers RDATA one cycle after each AR handshake. The two paths share only
// the register array.
//
// Parameters
//   C_S_AXI_DATA_WIDTH : 32 or 64
//   NUM_REGS           : power of two, 4..64
//   C_S_AXI_ADDR_WIDTH : derived; the MSB flags an out-of-range address
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET : clock and synchronous active-high reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*, S_AXI_AR*, S_AXI_R* : AXI4-Lite slave
//   reg_out   : flattened register contents, register k in slice k
//   wr_pulse  : one-cycle strobe per register when a write commits
//   status_in : only with PL_PS_AXI_STATUS_EN; gives the read values of the
//               upper half of the registers, which are then read-only
//
// Optional build macro: PL_PS_AXI_STATUS_EN
module pl_ps_axi_regbank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS           = 8,
   localparam int C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS*C_S_AXI_DATA_WIDTH/8) + 1
) (
   input  logic                                   S_AXI_ACLK,
   input  logic                                   S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
`ifdef PL_PS_AXI_STATUS_EN
   input  logic [NUM_REGS/2*C_S_AXI_DATA_WIDTH-1:0] status_in,
`endif
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]                    wr_pulse
);

   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int AW     = C_S_AXI_ADDR_WIDTH;
   localparam int STRB_W = DW/8;
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int OFF_W  = $clog2(STRB_W);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                          aw_held_q, aw_held_d;
   logic [AW-1:0]                 aw_addr_q, aw_addr_d;
   logic                          w_held_q, w_held_d;
   logic [DW-1:0]                 w_data_q, w_data_d;
   logic [STRB_W-1:0]             w_strb_q, w_strb_d;
   logic                          bvalid_q, bvalid_d;
   logic [1:0]                    bresp_q, bresp_d;
   logic                          rvalid_q, rvalid_d;
   logic [1:0]                    rresp_q, rresp_d;
   logic [DW-1:0]                 rdata_q, rdata_d;
   logic [NUM_REGS-1:0][DW-1:0]   regs_q, regs_d;
   logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;

   logic [IDX_W-1:0]              wr_idx, rd_idx;
   logic                          wr_ok, rd_in_range;
   logic                          aw_hs, w_hs, ar_hs;

   // The PROT inputs are ignored, and the byte-offset address bits play no
   // part in register selection.
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        aw_addr_q[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0]};

   // The readies are gated by reset so that they read 0 while reset is held
   // and go to 1 in the first cycle after release.
   assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_held_q && !bvalid_q;
   assign S_AXI_WREADY  = !S_AXI_ARESET && !w_held_q && !bvalid_q;
   assign S_AXI_ARREADY = !S_AXI_ARESET && !rvalid_q;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   assign wr_idx      = aw_addr_q[AW-2:OFF_W];
   assign rd_idx      = S_AXI_ARADDR[AW-2:OFF_W];
   assign rd_in_range = !S_AXI_ARADDR[AW-1];

`ifdef PL_PS_AXI_STATUS_EN
   // The upper half of the register space holds status and is read-only.
   assign wr_ok = !aw_addr_q[AW-1] && !wr_idx[IDX_W-1];
`else
   assign wr_ok = !aw_addr_q[AW-1];
`endif

   always_comb begin
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      regs_d     = regs_q;
      wr_pulse_d = '0;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = S_AXI_AWADDR;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      // Both slots full means no handshake can fill them this cycle, and
      // BVALID is known to be low.
      if (aw_held_q && w_held_q) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (w_strb_q[b]) begin
                  regs_d[wr_idx][b*8 +: 8] = w_data_q[b*8 +: 8];
               end
            end
            wr_pulse_d[wr_idx] = 1'b1;
            bresp_d            = RESP_OKAY;
         end else begin
            bresp_d = RESP_SLVERR;
         end
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      // RDATA is read from regs_q, so a write that commits on the same edge
      // is not seen; the read returns the value from before the write.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (!rd_in_range) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end else begin
            rresp_d = RESP_OKAY;
`ifdef PL_PS_AXI_STATUS_EN
            if (rd_idx[IDX_W-1]) begin
               rdata_d = status_in[int'(rd_idx[IDX_W-2:0])*DW +: DW];
            end else begin
               rdata_d = regs_q[rd_idx];
            end
`else
            rdata_d = regs_q[rd_idx];
`endif
         end
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         rvalid_q   <= 1'b0;
         rresp_q    <= '0;
         rdata_q    <= '0;
         regs_q     <= '0;
         wr_pulse_q <= '0;
      end else begin
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         regs_q     <= regs_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign reg_out      = regs_q;
   assign wr_pulse     = wr_pulse_q;

endmodule

// File: tb/tb_pl_ps_axi_regbank.sv
// Testbench for pl_ps_axi_regbank with default parameters (32-bit, 8 regs).
// The status-register checks are compiled only with PL_PS_AXI_STATUS_EN.
module tb_pl_ps_axi_regbank;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [NR*DW-1:0] reg_out;
   logic [NR-1:0]    wr_pulse;
`ifdef PL_PS_AXI_STATUS_EN
   logic [NR/2*DW-1:0] status_in;
`endif

   always #5 clk = ~clk;

   pl_ps_axi_regbank #(.C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready),
`ifdef PL_PS_AXI_STATUS_EN
      .status_in(status_in),
`endif
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int pulse_cnt [NR];
   logic [DW-1:0] model [NR];

   always @(negedge clk) begin
      for (int k = 0; k < NR; k++) if (wr_pulse[k]) pulse_cnt[k]++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pulse_sum();
      int s = 0;
      for (int k = 0; k < NR; k++) s += pulse_cnt[k];
      return s;
   endfunction

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
      return f;
   endfunction

   // Called just after a rising edge; returns after the B handshake.
   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, got = 0;
      resp = 2'bxx;
      awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bvalid) begin resp = bresp; got = 1; end
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         tick();
         if (aw_done) awvalid = 0;
         if (w_done) wvalid = 0;
      end
      check("write_done", got, 1);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp);
      bit ar_done = 0, got = 0;
      d = 'x; resp = 2'bxx;
      araddr = a; arvalid = 1; rready = 1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (rvalid) begin d = rdata; resp = rresp; got = 1; end
         if (arvalid && arready) ar_done = 1;
         tick();
         if (ar_done) arvalid = 0;
      end
      check("read_done", got, 1);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]    strb;
      logic [1:0]    bresp;
      int            idx;     // -1 marks an out-of-range access
      logic [DW-1:0] rdata;
      logic [1:0]    rresp;
   } vec_t;

   function automatic vec_t mk(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [3:0] s, input logic [1:0] br, input int i,
                               input logic [DW-1:0] rd, input logic [1:0] rr);
      vec_t v;
      v.addr = a; v.wdata = wd; v.strb = s; v.bresp = br;
      v.idx = i; v.rdata = rd; v.rresp = rr;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      logic [1:0]  r2, rr2;
      logic [DW-1:0] rd;
      int s0, p0;
      logic [DW-1:0] hold_rdata;
      logic [1:0]    hold_bresp, hold_rresp;
      bit stable;

      rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0;
      wvalid = 0; bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
`ifdef PL_PS_AXI_STATUS_EN
      status_in = '0;
      status_in[DW-1:0] = 32'hDEADBEEF;
`endif
      for (int k = 0; k < NR; k++) model[k] = '0;

      // Reset state
      tick(); tick();
      @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_reg_out", reg_out, 0);
      check("rst_wr_pulse", wr_pulse, 0);
      tick();
      rst = 0;
      @(negedge clk);
      check("rel_ready", {awready, wready, arready}, 3'b111);
      tick();

      // Table: each row writes, then reads back the same address
      vecs.push_back(mk(6'h00, 32'h1,        4'hF, 2'b00, 0,  32'h1,        2'b00));
      vecs.push_back(mk(6'h04, 32'h2,        4'hF, 2'b00, 1,  32'h2,        2'b00));
      vecs.push_back(mk(6'h08, 32'h3,        4'hF, 2'b00, 2,  32'h3,        2'b00));
      vecs.push_back(mk(6'h0C, 32'h4,        4'hF, 2'b00, 3,  32'h4,        2'b00));
      vecs.push_back(mk(6'h04, 32'hAABBCCDD, 4'hF, 2'b00, 1,  32'hAABBCCDD, 2'b00));
      vecs.push_back(mk(6'h04, 32'h11223344, 4'h5, 2'b00, 1,  32'hAA22CC44, 2'b00));
      vecs.push_back(mk(6'h20, 32'h55,       4'hF, 2'b10, -1, 32'h0,        2'b10));
      vecs.push_back(mk(6'h07, 32'h99000000, 4'h8, 2'b00, 1,  32'h9922CC44, 2'b00));
      vecs.push_back(mk(6'h3C, 32'hFFFFFFFF, 4'hF, 2'b10, -1, 32'h0,        2'b10));
`ifndef PL_PS_AXI_STATUS_EN
      vecs.push_back(mk(6'h18, 32'h0000600D, 4'h3, 2'b00, 6,  32'h0000600D, 2'b00));
`endif

      foreach (vecs[i]) begin
         s0 = pulse_sum();
         p0 = (vecs[i].idx >= 0) ? pulse_cnt[vecs[i].idx] : 0;
         axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r2);
         check($sformatf("v%0d_bresp", i), r2, vecs[i].bresp);
         axi_read(vecs[i].addr, rd, rr2);
         check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
         check($sformatf("v%0d_rresp", i), rr2, vecs[i].rresp);
         if (vecs[i].idx >= 0) begin
            model[vecs[i].idx] = vecs[i].rdata;
            check($sformatf("v%0d_pulse_idx", i), pulse_cnt[vecs[i].idx] - p0, 1);
            check($sformatf("v%0d_pulse_total", i), pulse_sum() - s0, 1);
         end else begin
            check($sformatf("v%0d_pulse_total", i), pulse_sum() - s0, 0);
         end
         check($sformatf("v%0d_reg_out", i), reg_out, model_flat());
      end

      // W three cycles before AW
      bready = 1;
      wdata = 32'hCAFE0002; wstrb = 4'hF; wvalid = 1;
      @(negedge clk);
      check("ord_wready", wready, 1);
      tick();
      wvalid = 0;
      @(negedge clk);
      check("ord_w_held", {wready, bvalid}, 2'b00);
      tick(); tick();
      awaddr = 6'h08; awvalid = 1;
      @(negedge clk);
      check("ord_awready", awready, 1);
      tick();
      awvalid = 0;
      @(negedge clk);
      check("ord_bvalid_early", bvalid, 0);
      tick();
      @(negedge clk);
      check("ord_bvalid", bvalid, 1);
      check("ord_bresp", bresp, 2'b00);
      check("ord_reg2", reg_out[2*DW +: DW], 32'hCAFE0002);
      tick();
      @(negedge clk);
      check("ord_bvalid_clr", bvalid, 0);
      tick();

      // AW and W together; a read of the same register lands on the commit edge
      awaddr = 6'h08; awvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1;
      @(negedge clk);
      tick();
      awvalid = 0; wvalid = 0;
      araddr = 6'h08; arvalid = 1; rready = 1;
      @(negedge clk);
      check("same_bvalid_early", bvalid, 0);
      check("same_arready", arready, 1);
      tick();
      arvalid = 0;
      @(negedge clk);
      check("same_bvalid", bvalid, 1);
      check("coll_rvalid", rvalid, 1);
      check("coll_rdata_prewrite", rdata, 32'hCAFE0002);
      check("same_reg2", reg_out[2*DW +: DW], 32'h0BADF00D);
      tick();

      // Backpressure: hold both responses, then reset mid-hold
      bready = 0; rready = 0;
      awaddr = 6'h00; awvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
      araddr = 6'h0C; arvalid = 1;
      @(negedge clk);
      tick();
      awaddr = 6'h08; wdata = 32'h5A5A5A5A; araddr = 6'h00;
      tick();
      @(negedge clk);
      check("bp_bvalid", bvalid, 1);
      check("bp_rvalid", rvalid, 1);
      check("bp_rdata", rdata, 32'h4);
      check("bp_reg0", reg_out[0 +: DW], 32'h12345678);
      hold_rdata = rdata; hold_bresp = bresp; hold_rresp = rresp;
      stable = 1;
      for (int c = 0; c < 10; c++) begin
         tick();
         @(negedge clk);
         if (!bvalid || !rvalid || rdata !== hold_rdata || bresp !== hold_bresp ||
             rresp !== hold_rresp || awready || wready || arready)
            stable = 0;
      end
      check("bp_stable", stable, 1);
      check("bp_reg2_untouched", reg_out[2*DW +: DW], 32'h0BADF00D);
      tick();
      rst = 1; awvalid = 0; wvalid = 0; arvalid = 0;
      tick();
      @(negedge clk);
      check("mid_rst_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_pulse", wr_pulse, 0);
      check("mid_rst_regs", reg_out, 0);
      tick();
      rst = 0;
      @(negedge clk);
      check("post_rst_ready", {awready, wready, arready}, 3'b111);
      for (int k = 0; k < NR; k++) model[k] = '0;
      tick();
      axi_read(6'h0C, rd, rr2);
      check("post_rst_reg3", rd, 0);

      // A W slot captured before reset must be discarded
      bready = 1;
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
      @(negedge clk);
      tick();
      wvalid = 0; rst = 1;
      tick();
      rst = 0;
      awaddr = 6'h00; awvalid = 1;
      @(negedge clk);
      tick();
      awvalid = 0;
      stable = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bvalid || !wready) stable = 0;
         tick();
      end
      check("abandon_no_commit", stable, 1);
      wdata = 32'h88; wvalid = 1;
      @(negedge clk);
      tick();
      wvalid = 0;
      tick();
      @(negedge clk);
      check("abandon_late_commit", bvalid, 1);
      check("abandon_reg0", reg_out[0 +: DW], 32'h88);
      tick();
      tick();

`ifdef PL_PS_AXI_STATUS_EN
      axi_read(6'h10, rd, rr2);
      check("stat_rdata", rd, 32'hDEADBEEF);
      check("stat_rresp", rr2, 2'b00);
      s0 = pulse_sum();
      axi_write(6'h10, 32'h12121212, 4'hF, r2);
      check("stat_bresp", r2, 2'b10);
      tick();
      check("stat_no_pulse", pulse_sum() - s0, 0);
      check("stat_reg4", reg_out[4*DW +: DW], 0);
      axi_read(6'h10, rd, rr2);
      check("stat_rdata_after", rd, 32'hDEADBEEF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
